or_evt_filter: RTL

- Sequential consumer of the switch-level OR gate output (`out` of the two-input OR cell): one asynchronous, glitch-prone level.
- Synchronises and debounces that level, then exposes a clean registered level, a one-cycle rise pulse, a saturating event count, and a valid/ready event report.
- Sits between the transistor-level gate library and the clocked control logic.

---
 rtl/or_evt_filter.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/or_evt_filter.sv
// Conditions the raw OR-gate output into a clean level plus rise events:
// synchroniser, debounce FSM, saturating rise counter and a valid/ready event report.
module or_evt_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE    = 4,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             or_in,
  input  logic             clr,
  output logic             level,
  output logic             rise_pulse,
  output logic [CNT_W-1:0] evt_count,
  output logic             sat,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [CNT_W-1:0] evt_data,
  output logic             drop
);

  localparam int              DCW     = $clog2(DEBOUNCE + 1);
  localparam logic [DCW-1:0]  DB_LAST = DCW'(DEBOUNCE - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE_LO, QUAL_HI, IDLE_HI, QUAL_LO} state_t;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  state_t                 state_q, state_d;
  logic [DCW-1:0]         dbc_q, dbc_d;
  logic                   level_q, level_d;
  logic                   rise_pulse_q, rise_pulse_d;
  logic [CNT_W-1:0]       evt_count_q, evt_count_d;
  logic                   sat_q, sat_d;
  logic                   evt_valid_q, evt_valid_d;
  logic [CNT_W-1:0]       evt_data_q, evt_data_d;
  logic                   drop_q, drop_d;

  logic                   s;
  logic                   commit_rise;
  logic                   commit_fall;
  logic                   xfer;
  logic [CNT_W-1:0]       count_base;

  assign sync_d = {sync_q[SYNC_STAGES-2:0], or_in};
  assign s      = sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d     = state_q;
    dbc_d       = dbc_q;
    commit_rise = 1'b0;
    commit_fall = 1'b0;
    case (state_q)
      IDLE_LO: begin
        if (s) begin
          if (DEBOUNCE == 1) begin
            commit_rise = 1'b1;
            state_d     = IDLE_HI;
            dbc_d       = '0;
          end else begin
            state_d = QUAL_HI;
            dbc_d   = DCW'(1);
          end
        end
      end
      QUAL_HI: begin
        if (!s) begin
          state_d = IDLE_LO;
          dbc_d   = '0;
        end else if (dbc_q == DB_LAST) begin
          commit_rise = 1'b1;
          state_d     = IDLE_HI;
          dbc_d       = '0;
        end else begin
          dbc_d = dbc_q + 1'b1;
        end
      end
      IDLE_HI: begin
        if (!s) begin
          if (DEBOUNCE == 1) begin
            commit_fall = 1'b1;
            state_d     = IDLE_LO;
            dbc_d       = '0;
          end else begin
            state_d = QUAL_LO;
            dbc_d   = DCW'(1);
          end
        end
      end
      QUAL_LO: begin
        if (s) begin
          state_d = IDLE_HI;
          dbc_d   = '0;
        end else if (dbc_q == DB_LAST) begin
          commit_fall = 1'b1;
          state_d     = IDLE_LO;
          dbc_d       = '0;
        end else begin
          dbc_d = dbc_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE_LO;
        dbc_d   = '0;
      end
    endcase
  end

  // clr is applied before the increment so clr + rise yields a count of one.
  always_comb begin
    level_d      = level_q;
    rise_pulse_d = commit_rise;
    count_base   = clr ? '0 : evt_count_q;
    evt_count_d  = count_base;
    xfer         = evt_valid_q && evt_ready;
    evt_valid_d  = evt_valid_q;
    evt_data_d   = evt_data_q;

    if (commit_rise) begin
      level_d = 1'b1;
    end else if (commit_fall) begin
      level_d = 1'b0;
    end

    if (commit_rise && (count_base != CNT_MAX)) begin
      evt_count_d = count_base + 1'b1;
    end

    sat_d  = (clr ? 1'b0 : sat_q) | (commit_rise && (evt_count_d == CNT_MAX));
    drop_d = (clr ? 1'b0 : drop_q) | (commit_rise && evt_valid_q && !evt_ready);

    if (commit_rise && (!evt_valid_q || xfer)) begin
      evt_valid_d = 1'b1;
      evt_data_d  = evt_count_d;
    end else if (xfer) begin
      evt_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q       <= '0;
      state_q      <= IDLE_LO;
      dbc_q        <= '0;
      level_q      <= 1'b0;
      rise_pulse_q <= 1'b0;
      evt_count_q  <= '0;
      sat_q        <= 1'b0;
      evt_valid_q  <= 1'b0;
      evt_data_q   <= '0;
      drop_q       <= 1'b0;
    end else begin
      sync_q       <= sync_d;
      state_q      <= state_d;
      dbc_q        <= dbc_d;
      level_q      <= level_d;
      rise_pulse_q <= rise_pulse_d;
      evt_count_q  <= evt_count_d;
      sat_q        <= sat_d;
      evt_valid_q  <= evt_valid_d;
      evt_data_q   <= evt_data_d;
      drop_q       <= drop_d;
    end
  end

  assign level      = level_q;
  assign rise_pulse = rise_pulse_q;
  assign evt_count  = evt_count_q;
  assign sat        = sat_q;
  assign evt_valid  = evt_valid_q;
  assign evt_data   = evt_data_q;
  assign drop       = drop_q;

endmodule
